// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM and owner
// encodings, default widths and the saturating counter helper.
package mips_mem_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

  // Wide enough for the largest legal MEM_LAT (7) and STARVE_MAX (15).
  localparam int LAT_CNT_W = 3;
  localparam int STARVE_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Increment that sticks at the supplied ceiling.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                  input logic [STARVE_W-1:0] ceil);
    return (v >= ceil) ? ceil : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_grant_select.sv
// Priority select between fetch and data requests. Data normally wins; once
// STARVE_MAX data grants have been made while a fetch was waiting, the next
// contested arbitration goes to fetch so the pipeline front end always moves.
module mem_grant_select
  import mips_mem_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_arb_en,
  input  logic                i_if_req,
  input  logic                i_d_req,
  output logic                o_grant,
  output owner_e              o_grant_own,
  output logic [STARVE_W-1:0] o_starve_cnt
);

  localparam logic [STARVE_W-1:0] SMAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] r_starve_cnt;
  logic                w_force_if;

  // Combinational grant: who would win if arbitration is enabled this cycle.
  always_comb begin
    w_force_if  = (r_starve_cnt == SMAX);
    o_grant     = i_arb_en & (i_if_req | i_d_req);
    o_grant_own = OWN_IF;
    if (i_d_req && !(i_if_req && w_force_if)) begin
      o_grant_own = OWN_D;
    end
  end

  // Starvation count: bump on data grants that pass over a waiting fetch,
  // clear whenever fetch is granted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
    end else if (o_grant) begin
      if (o_grant_own == OWN_IF) begin
        r_starve_cnt <= '0;
      end else if (i_if_req) begin
        r_starve_cnt <= sat_inc(r_starve_cnt, SMAX);
      end
    end
  end

  assign o_starve_cnt = r_starve_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between the IF
// stage (fetch) and the MEM stage (load/store). One access is in flight at a
// time: IDLE grants, ISSUE strobes the memory, WAIT counts out the read
// latency, DONE pulses the owner's Ready.
//
// Requester handshake: a requester raises Req with stable Addr (and, for
// data, Write/WData) and holds it until its one-cycle Ready pulse; the
// transfer completes in the Ready cycle, read data is valid in that cycle
// and held afterwards. Req may stay high after Ready to present the next
// request. Dropping Req before Ready is illegal; the access still completes.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                IF_Req,
  input  logic [ADDR_W-1:0]   IF_Addr,
  output logic                IF_Ready,
  output logic [DATA_W-1:0]   IF_Data,
  input  logic                D_Req,
  input  logic                D_Write,
  input  logic [ADDR_W-1:0]   D_Addr,
  input  logic [DATA_W-1:0]   D_WData,
  output logic                D_Ready,
  output logic [DATA_W-1:0]   D_RData,
  output logic                Mem_En,
  output logic                Mem_We,
  output logic [ADDR_W-1:0]   Mem_Addr,
  output logic [DATA_W-1:0]   Mem_WData,
  input  logic [DATA_W-1:0]   Mem_RData,
  output logic                Stall_IF,
  output logic                Stall_MEM,
  output arb_state_e          Dbg_State,
  output logic [STARVE_W-1:0] Dbg_Starve
);

  arb_state_e             r_state;
  arb_state_e             w_next;
  owner_e                 r_owner;
  logic                   r_we;
  logic                   r_mem_en;
  logic                   r_mem_we;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [LAT_CNT_W-1:0]   r_lat_cnt;
  logic [DATA_W-1:0]      r_if_data;
  logic [DATA_W-1:0]      r_d_rdata;

  logic                   w_arb_en;
  logic                   w_grant;
  owner_e                 w_grant_own;
  logic                   w_capture;
  logic                   w_done;

  // Arbitration only in IDLE; DONE is skipped because the owner's Req is
  // still high there and would be granted a second time.
  assign w_arb_en = (r_state == ST_IDLE);

  mem_grant_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .i_clk        (Clk),
    .i_rst        (Rst),
    .i_arb_en     (w_arb_en),
    .i_if_req     (IF_Req),
    .i_d_req      (D_Req),
    .o_grant      (w_grant),
    .o_grant_own  (w_grant_own),
    .o_starve_cnt (Dbg_Starve)
  );

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; capture strobe fires in the last WAIT cycle.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_grant) w_next = ST_ISSUE;
      ST_ISSUE: w_next = r_we ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (r_lat_cnt == LAT_CNT_W'(1)) begin
          w_capture = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Access datapath: latch the granted request, strobe the memory for one
  // cycle, count the read latency and capture read data for the owner.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_owner   <= OWN_IF;
      r_we      <= 1'b0;
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_lat_cnt <= '0;
      r_if_data <= '0;
      r_d_rdata <= '0;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      if (w_grant) begin
        r_owner  <= w_grant_own;
        r_mem_en <= 1'b1;
        if (w_grant_own == OWN_D) begin
          r_addr   <= D_Addr;
          r_we     <= D_Write;
          r_mem_we <= D_Write;
          if (D_Write) begin
            r_wdata <= D_WData;
          end
        end else begin
          r_addr <= IF_Addr;
          r_we   <= 1'b0;
        end
      end
      if (r_state == ST_ISSUE) begin
        r_lat_cnt <= LAT_CNT_W'(MEM_LAT);
      end else if (r_state == ST_WAIT) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
      if (w_capture) begin
        if (r_owner == OWN_D) begin
          r_d_rdata <= Mem_RData;
        end else begin
          r_if_data <= Mem_RData;
        end
      end
    end
  end

  assign w_done    = (r_state == ST_DONE) & ~Rst;
  assign IF_Ready  = w_done & (r_owner == OWN_IF);
  assign D_Ready   = w_done & (r_owner == OWN_D);
  assign IF_Data   = r_if_data;
  assign D_RData   = r_d_rdata;
  assign Mem_En    = r_mem_en;
  assign Mem_We    = r_mem_we;
  assign Mem_Addr  = r_addr;
  assign Mem_WData = r_wdata;
  assign Stall_IF  = ~Rst & IF_Req & ~IF_Ready;
  assign Stall_MEM = ~Rst & D_Req & ~D_Ready;
  assign Dbg_State = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then random two-requester traffic with occasional resets, all checked every
// cycle against a transaction-timing model of the arbiter.
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic                IF_Req = 1'b0, D_Req = 1'b0, D_Write = 1'b0;
  logic [31:0]         IF_Addr = '0, D_Addr = '0, D_WData = '0;
  logic [31:0]         Mem_RData = '0;
  logic                IF_Ready, D_Ready, Mem_En, Mem_We, Stall_IF, Stall_MEM;
  logic [31:0]         IF_Data, D_RData, Mem_Addr, Mem_WData;
  arb_state_e          Dbg_State;
  logic [STARVE_W-1:0] Dbg_Starve;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Ready(IF_Ready), .IF_Data(IF_Data),
    .D_Req(D_Req), .D_Write(D_Write), .D_Addr(D_Addr), .D_WData(D_WData),
    .D_Ready(D_Ready), .D_RData(D_RData),
    .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_RData(Mem_RData), .Stall_IF(Stall_IF), .Stall_MEM(Stall_MEM),
    .Dbg_State(Dbg_State), .Dbg_Starve(Dbg_Starve)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory contents ----------------
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] fill(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  function automatic logic [31:0] rd_env(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : fill(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    env_mem[a] = d;
    ref_mem[a] = d;
  endtask

  // ---------------- memory device ----------------
  logic        rd_pend = 1'b0;
  int          rd_due  = 0;
  logic [31:0] rd_val  = '0;

  // Accept accesses; a read answers exactly LAT cycles after its Mem_En.
  always @(negedge Clk) begin : mem_accept
    if (Mem_En === 1'b1) begin
      if (Mem_We) begin
        env_mem[Mem_Addr] = Mem_WData;
      end else begin
        rd_pend = 1'b1;
        rd_due  = cyc + LAT;
        rd_val  = rd_env(Mem_Addr);
      end
    end
  end

  // Drive read data in its due cycle, noise otherwise.
  always @(posedge Clk) begin : mem_drive
    #1;
    if (rd_pend && cyc == rd_due) begin
      Mem_RData = rd_val;
      rd_pend   = 1'b0;
    end else begin
      Mem_RData = $urandom;
    end
  end

  // ---------------- protocol check ----------------
  logic p_rst = 1'b1, p_if_req = 1'b0, p_if_rdy = 1'b0, p_d_req = 1'b0, p_d_rdy = 1'b0;
  always @(negedge Clk) begin : proto
    if (!Rst && !p_rst) begin
      assert (!(p_if_req && !p_if_rdy && !IF_Req))
        else $error("protocol violation: IF_Req dropped before IF_Ready");
      assert (!(p_d_req && !p_d_rdy && !D_Req))
        else $error("protocol violation: D_Req dropped before D_Ready");
    end
    p_rst = Rst; p_if_req = IF_Req; p_if_rdy = IF_Ready;
    p_d_req = D_Req; p_d_rdy = D_Ready;
  end

  // ---------------- reference model + compare ----------------
  // One transaction at a time; outputs follow from its age in cycles:
  // age 1 strobes memory, reads finish at age LAT+2, stores at age 2.
  logic        m_busy = 1'b0, m_d = 1'b0, m_wr = 1'b0;
  int          m_t0 = 0, m_starve = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_data = '0, m_d_rdata = '0;

  always @(negedge Clk) begin : model
    logic        e_en, e_we, e_if_rdy, e_d_rdy;
    logic [1:0]  e_st;
    logic [31:0] x;
    int          off, done_off;
    e_en = 1'b0; e_we = 1'b0; e_if_rdy = 1'b0; e_d_rdy = 1'b0; e_st = 2'd0;
    off = 0; done_off = 0;
    if (m_busy) begin
      off      = cyc - m_t0;
      done_off = m_wr ? 2 : 2 + LAT;
      if (off == 1) begin
        e_en = 1'b1; e_we = m_wr; e_st = 2'd1;
      end else if (off == done_off) begin
        e_st = 2'd3;
        if (!Rst) begin e_if_rdy = !m_d; e_d_rdy = m_d; end
      end else begin
        e_st = 2'd2;
      end
    end
    chk("if_ready",  64'(IF_Ready),   64'(e_if_rdy));
    chk("d_ready",   64'(D_Ready),    64'(e_d_rdy));
    chk("mem_en",    64'(Mem_En),     64'(e_en));
    chk("mem_we",    64'(Mem_We),     64'(e_we));
    chk("mem_addr",  64'(Mem_Addr),   64'(m_addr));
    chk("mem_wdata", 64'(Mem_WData),  64'(m_wdata));
    chk("if_data",   64'(IF_Data),    64'(m_if_data));
    chk("d_rdata",   64'(D_RData),    64'(m_d_rdata));
    chk("stall_if",  64'(Stall_IF),   64'(!Rst && IF_Req && !e_if_rdy));
    chk("stall_mem", 64'(Stall_MEM),  64'(!Rst && D_Req && !e_d_rdy));
    chk("state",     64'(Dbg_State),  64'(e_st));
    chk("starve",    64'(Dbg_Starve), 64'(m_starve));
    // advance to the next cycle
    if (Rst) begin
      m_busy = 1'b0; m_starve = 0; m_addr = '0; m_wdata = '0;
      m_if_data = '0; m_d_rdata = '0; exp_q.delete();
    end else if (m_busy) begin
      if (!m_wr && off == 1 + LAT) begin
        x = exp_q.pop_front();
        if (m_d) m_d_rdata = x; else m_if_data = x;
      end
      if (off == done_off) m_busy = 1'b0;
    end else if (D_Req && (!IF_Req || m_starve != SMAX)) begin
      m_busy = 1'b1; m_t0 = cyc; m_d = 1'b1; m_wr = D_Write; m_addr = D_Addr;
      if (D_Write) begin
        m_wdata = D_WData;
        ref_mem[D_Addr] = D_WData;
      end else begin
        exp_q.push_back(rd_ref(D_Addr));
      end
      if (IF_Req && m_starve < SMAX) m_starve++;
    end else if (IF_Req) begin
      m_busy = 1'b1; m_t0 = cyc; m_d = 1'b0; m_wr = 1'b0; m_addr = IF_Addr;
      exp_q.push_back(rd_ref(IF_Addr));
      m_starve = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_fetch();
    step(); IF_Req = 1'b1; IF_Addr = 32'h40;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      if (k == 1) begin
        chk("fetch_en",   64'(Mem_En),   64'd1);
        chk("fetch_we",   64'(Mem_We),   64'd0);
        chk("fetch_addr", 64'(Mem_Addr), 64'h40);
      end
      if (k < 4) chk("fetch_stall", 64'(Stall_IF), 64'd1);
      if (k == 4) begin
        chk("fetch_rdy",  64'(IF_Ready), 64'd1);
        chk("fetch_data", 64'(IF_Data),  64'h8C220004);
      end
      step();
    end
    IF_Req = 1'b0;
  endtask

  task automatic test_store();
    step(); D_Req = 1'b1; D_Write = 1'b1; D_Addr = 32'h100; D_WData = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (k == 1) begin
        chk("st_en",    64'(Mem_En),    64'd1);
        chk("st_we",    64'(Mem_We),    64'd1);
        chk("st_addr",  64'(Mem_Addr),  64'h100);
        chk("st_wdata", 64'(Mem_WData), 64'hDEADBEEF);
      end
      chk("st_d_rdy",  64'(D_Ready),  (k == 2) ? 64'd1 : 64'd0);
      chk("st_if_rdy", 64'(IF_Ready), 64'd0);
      step();
    end
    D_Req = 1'b0; D_Write = 1'b0;
  endtask

  task automatic test_simul();
    step(); IF_Req = 1'b1; IF_Addr = 32'h200; D_Req = 1'b1; D_Write = 1'b0; D_Addr = 32'h104;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (k == 4) begin
        chk("sim_d_rdy",  64'(D_Ready), 64'd1);
        chk("sim_d_data", 64'(D_RData), 64'h12345678);
      end
      if (k == 5) chk("sim_grant_idle", 64'(Dbg_State), 64'(ST_IDLE));
      if (k == 6) begin
        chk("sim_f_en",   64'(Mem_En),   64'd1);
        chk("sim_f_addr", 64'(Mem_Addr), 64'h200);
      end
      chk("sim_if_rdy", 64'(IF_Ready), (k == 9) ? 64'd1 : 64'd0);
      step();
      if (k == 4) D_Req = 1'b0;
    end
    IF_Req = 1'b0;
  endtask

  task automatic test_starve();
    int   n_d;
    logic got, fin, s_if, s_d;
    n_d = 0; got = 1'b0; fin = 1'b0;
    step(); IF_Req = 1'b1; IF_Addr = 32'h300; D_Req = 1'b1; D_Write = 1'b0; D_Addr = 32'h400;
    for (int k = 0; k < 100 && !fin; k++) begin
      @(negedge Clk);
      s_if = IF_Ready; s_d = D_Ready;
      if (s_d && !got) begin
        n_d++;
        if (n_d == SMAX) chk("starve_cnt_max", 64'(Dbg_Starve), 64'd4);
      end
      if (s_if) begin
        got = 1'b1;
        chk("starve_n_data", 64'(n_d), 64'd4);
        chk("starve_cnt_clr", 64'(Dbg_Starve), 64'd0);
      end
      step();
      if (s_if) IF_Req = 1'b0;
      if (got && s_d) begin D_Req = 1'b0; fin = 1'b1; end
    end
    if (!fin) chk("starve_timeout", 64'd0, 64'd1);
  endtask

  task automatic test_reset();
    step(); IF_Req = 1'b1; IF_Addr = 32'h700;
    @(negedge Clk); step();
    @(negedge Clk); step();
    Rst = 1'b1; IF_Req = 1'b0;
    @(negedge Clk);
    chk("rst_in_wait", 64'(Dbg_State), 64'(ST_WAIT));
    step(); Rst = 1'b0;
    @(negedge Clk);
    chk("rst_state", 64'(Dbg_State), 64'(ST_IDLE));
    chk("rst_en",    64'(Mem_En),    64'd0);
    chk("rst_addr",  64'(Mem_Addr),  64'd0);
    chk("rst_wdata", 64'(Mem_WData), 64'd0);
    chk("rst_ifd",   64'(IF_Data),   64'd0);
    chk("rst_drd",   64'(D_RData),   64'd0);
    chk("rst_cnt",   64'(Dbg_Starve), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step(); @(negedge Clk);
      chk("rst_no_rdy", 64'(IF_Ready), 64'd0);
    end
    step(); IF_Req = 1'b1; IF_Addr = 32'h500;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      if (k == 4) begin
        chk("rst_new_rdy",  64'(IF_Ready), 64'd1);
        chk("rst_new_data", 64'(IF_Data),  64'hCAFEF00D);
      end
      step();
    end
    IF_Req = 1'b0;
  endtask

  task automatic test_b2b();
    int t1, t2;
    t1 = -1; t2 = -1;
    step(); D_Req = 1'b1; D_Write = 1'b0; D_Addr = 32'h600;
    for (int k = 0; k < 30 && t2 < 0; k++) begin
      @(negedge Clk);
      if (D_Ready) begin
        if (t1 < 0) begin
          t1 = k;
          chk("b2b_data0", 64'(D_RData), 64'h11111111);
        end else begin
          t2 = k;
          chk("b2b_data1", 64'(D_RData), 64'h22222222);
        end
      end
      step();
      if (t1 == k) D_Addr = 32'h604;
      if (t2 == k) D_Req = 1'b0;
    end
    chk("b2b_first",   64'(t1),      64'd4);
    chk("b2b_spacing", 64'(t2 - t1), 64'd5);
    if (t2 < 0) D_Req = 1'b0;
  endtask

  task automatic random_traffic(input int n);
    logic ifr, dr;
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      ifr = IF_Ready; dr = D_Ready;
      step();
      if (Rst) begin
        Rst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        Rst = 1'b1; IF_Req = 1'b0; D_Req = 1'b0;
      end else begin
        if (IF_Req) begin
          if (ifr) begin
            if ($urandom_range(0, 1) == 1) IF_Req = 1'b0;
            else IF_Addr = 32'($urandom_range(0, 63)) << 2;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          IF_Req = 1'b1; IF_Addr = 32'($urandom_range(0, 63)) << 2;
        end
        if (D_Req) begin
          if (dr) begin
            if ($urandom_range(0, 2) == 0) D_Req = 1'b0;
            else begin
              D_Write = 1'($urandom_range(0, 1));
              D_Addr  = 32'($urandom_range(0, 63)) << 2;
              D_WData = $urandom;
            end
          end
        end else if ($urandom_range(0, 1) == 0) begin
          D_Req   = 1'b1;
          D_Write = 1'($urandom_range(0, 1));
          D_Addr  = 32'($urandom_range(0, 63)) << 2;
          D_WData = $urandom;
        end
      end
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    preload(32'h40,  32'h8C220004);
    preload(32'h104, 32'h12345678);
    preload(32'h500, 32'hCAFEF00D);
    preload(32'h600, 32'h11111111);
    preload(32'h604, 32'h22222222);
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    test_fetch();
    test_store();
    test_simul();
    test_starve();
    test_reset();
    test_b2b();
    random_traffic(4000);
    @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
